// File: rtl/draw_card_grid_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : draw_card_grid_pkg                                          |
// | Card state/face encodings, face palette and VGA bus field layout.    |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package draw_card_grid_pkg;

  // Bus layout, MSB first: {hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0]}
  localparam int c_vga_bus_size = 38;
  localparam int c_rgb_lsb      = 0;
  localparam int c_vblnk_bit    = 12;
  localparam int c_hblnk_bit    = 13;
  localparam int c_vsync_bit    = 14;
  localparam int c_hsync_bit    = 15;
  localparam int c_vcount_lsb   = 16;
  localparam int c_hcount_lsb   = 27;

  localparam int c_state_w = 2;
  localparam int c_face_w  = 4;
  localparam int c_entry_w = c_state_w + c_face_w;

  typedef enum logic [1:0] {
    CARD_HIDDEN   = 2'b00,
    CARD_REVEALED = 2'b01,
    CARD_MATCHED  = 2'b10,
    CARD_REMOVED  = 2'b11
  } card_state_e;

  typedef enum logic [1:0] {
    SYNC_IDLE    = 2'b00,
    SYNC_PENDING = 2'b01,
    SYNC_DONE    = 2'b10
  } sync_state_e;

  function automatic logic [11:0] face_color(input logic [c_face_w-1:0] face);
    logic [11:0] rgb;
    case (face)
      4'd0:    rgb = 12'hF00;
      4'd1:    rgb = 12'h00F;
      4'd2:    rgb = 12'hF0F;
      4'd3:    rgb = 12'h0FF;
      4'd4:    rgb = 12'hF80;
      4'd5:    rgb = 12'h80F;
      4'd6:    rgb = 12'h08F;
      4'd7:    rgb = 12'hFFF;
      4'd8:    rgb = 12'h800;
      4'd9:    rgb = 12'h008;
      4'd10:   rgb = 12'h880;
      4'd11:   rgb = 12'h088;
      4'd12:   rgb = 12'h808;
      4'd13:   rgb = 12'hF88;
      4'd14:   rgb = 12'h8F8;
      default: rgb = 12'h88F;
    endcase
    return rgb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/draw_card_grid_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : card_grid_bank                                              |
// | Shadow/active card storage with vblank-aligned commit handshake.     |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module card_grid_bank
  import draw_card_grid_pkg::*;
#(
  parameter int NUM_CARDS = 12,
  parameter int IDX_W     = 4
) (
  input  logic                           pclk,
  input  logic                           rst,
  input  logic                           vblnk,
  input  logic                           upd_valid,
  output logic                           upd_ready,
  input  logic [IDX_W-1:0]               upd_idx,
  input  logic [c_state_w-1:0]           upd_state,
  input  logic [c_face_w-1:0]            upd_face,
  input  logic                           regfile_sync,
  output logic                           regfile_sync_done,
  output logic [NUM_CARDS*c_entry_w-1:0] active_bank
);

  localparam logic [IDX_W:0] c_num_cards = (IDX_W+1)'(NUM_CARDS);

  sync_state_e r_state;
  sync_state_e w_state_nxt;
  logic        r_vblnk_prev;
  logic        w_vblnk_rise;
  logic        w_commit;
  logic        w_wr_en;

  assign w_vblnk_rise = vblnk & ~r_vblnk_prev;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_state      <= SYNC_IDLE;
      r_vblnk_prev <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_vblnk_prev <= vblnk;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    upd_ready         = 1'b0;
    regfile_sync_done = 1'b0;
    w_commit          = 1'b0;
    case (r_state)
      SYNC_IDLE: begin
        upd_ready = 1'b1;
        if (regfile_sync) w_state_nxt = SYNC_PENDING;
      end
      SYNC_PENDING: begin
        if (w_vblnk_rise) begin
          w_commit    = 1'b1;
          w_state_nxt = SYNC_DONE;
        end
      end
      SYNC_DONE: begin
        regfile_sync_done = 1'b1;
        w_state_nxt       = SYNC_IDLE;
      end
      default: w_state_nxt = SYNC_IDLE;
    endcase
  end

  // Out-of-range indices complete the handshake but never match a card slot.
  assign w_wr_en = upd_valid & upd_ready & ({1'b0, upd_idx} < c_num_cards);

  for (genvar i = 0; i < NUM_CARDS; i++) begin : g_card
    logic [c_entry_w-1:0] r_shadow;
    logic [c_entry_w-1:0] r_active;

    always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
        r_shadow <= '0;
        r_active <= '0;
      end else begin
        if (w_wr_en && (upd_idx == IDX_W'(i))) r_shadow <= {upd_state, upd_face};
        if (w_commit)                          r_active <= r_shadow;
      end
    end

    assign active_bank[i*c_entry_w +: c_entry_w] = r_active;
  end

endmodule
`default_nettype wire

// File: rtl/draw_card_grid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : draw_card_grid                                              |
// | Two-stage VGA bus renderer for the memory-game card grid.            |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module draw_card_grid
  import draw_card_grid_pkg::*;
#(
  parameter int          NUM_X        = 4,
  parameter int          NUM_Y        = 3,
  parameter int          X0           = 50,
  parameter int          Y0           = 50,
  parameter int          CARD_W       = 150,
  parameter int          CARD_H       = 200,
  parameter int          PITCH_X      = 258,
  parameter int          PITCH_Y      = 234,
  parameter int          BORDER       = 4,
  parameter logic [11:0] BACK_COLOR   = 12'h0F0,
  parameter logic [11:0] MATCH_COLOR  = 12'h444,
  parameter logic [11:0] CURSOR_COLOR = 12'hFF0,
  localparam int         NUM_CARDS    = NUM_X * NUM_Y,
  localparam int         IDX_W        = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1
) (
  input  logic                      pclk,
  input  logic                      rst,
  input  logic [c_vga_bus_size-1:0] vga_in,
  output logic [c_vga_bus_size-1:0] vga_out,
  input  logic                      upd_valid,
  output logic                      upd_ready,
  input  logic [IDX_W-1:0]          upd_idx,
  input  logic [c_state_w-1:0]      upd_state,
  input  logic [c_face_w-1:0]       upd_face,
  input  logic                      regfile_sync,
  output logic                      regfile_sync_done,
  input  logic                      cursor_en,
  input  logic [IDX_W-1:0]          cursor_idx
);

  if (NUM_X < 1 || NUM_X > 8 || NUM_Y < 1 || NUM_Y > 8 ||
      PITCH_X < CARD_W || PITCH_Y < CARD_H ||
      CARD_W <= 2*BORDER || CARD_H <= 2*BORDER ||
      X0 + (NUM_X-1)*PITCH_X + CARD_W > 4095 ||
      Y0 + (NUM_Y-1)*PITCH_Y + CARD_H > 4095) begin : g_bad_params
    $error("draw_card_grid: illegal card grid parameters");
  end

  logic [NUM_CARDS*c_entry_w-1:0] w_active_bank;

  card_grid_bank #(
    .NUM_CARDS (NUM_CARDS),
    .IDX_W     (IDX_W)
  ) u_bank (
    .pclk              (pclk),
    .rst               (rst),
    .vblnk             (vga_in[c_vblnk_bit]),
    .upd_valid         (upd_valid),
    .upd_ready         (upd_ready),
    .upd_idx           (upd_idx),
    .upd_state         (upd_state),
    .upd_face          (upd_face),
    .regfile_sync      (regfile_sync),
    .regfile_sync_done (regfile_sync_done),
    .active_bank       (w_active_bank)
  );

  logic [11:0]      w_h;
  logic [11:0]      w_v;
  logic [NUM_X-1:0] w_col_hit;
  logic [NUM_X-1:0] w_col_band;
  logic [NUM_Y-1:0] w_row_hit;
  logic [NUM_Y-1:0] w_row_band;

  assign w_h = {1'b0, vga_in[c_hcount_lsb +: 11]};
  assign w_v = {1'b0, vga_in[c_vcount_lsb +: 11]};

  // Band flags are only meaningful together with the matching hit flag.
  for (genvar c = 0; c < NUM_X; c++) begin : g_col
    localparam logic [11:0] c_lo      = 12'(X0 + c*PITCH_X);
    localparam logic [11:0] c_hi      = 12'(X0 + c*PITCH_X + CARD_W);
    localparam logic [11:0] c_band_lo = 12'(X0 + c*PITCH_X + BORDER);
    localparam logic [11:0] c_band_hi = 12'(X0 + c*PITCH_X + CARD_W - BORDER);
    assign w_col_hit[c]  = (w_h >= c_lo) && (w_h < c_hi);
    assign w_col_band[c] = (w_h < c_band_lo) || (w_h >= c_band_hi);
  end

  for (genvar r = 0; r < NUM_Y; r++) begin : g_row
    localparam logic [11:0] c_lo      = 12'(Y0 + r*PITCH_Y);
    localparam logic [11:0] c_hi      = 12'(Y0 + r*PITCH_Y + CARD_H);
    localparam logic [11:0] c_band_lo = 12'(Y0 + r*PITCH_Y + BORDER);
    localparam logic [11:0] c_band_hi = 12'(Y0 + r*PITCH_Y + CARD_H - BORDER);
    assign w_row_hit[r]  = (w_v >= c_lo) && (w_v < c_hi);
    assign w_row_band[r] = (w_v < c_band_lo) || (w_v >= c_band_hi);
  end

  logic       w_col_any, w_col_edge, w_row_any, w_row_edge;
  logic [2:0] w_col_idx, w_row_idx;

  always_comb begin
    w_col_any  = 1'b0;
    w_col_edge = 1'b0;
    w_col_idx  = '0;
    for (int c = 0; c < NUM_X; c++) begin
      if (w_col_hit[c]) begin
        w_col_any  = 1'b1;
        w_col_edge = w_col_band[c];
        w_col_idx  = 3'(c);
      end
    end
  end

  always_comb begin
    w_row_any  = 1'b0;
    w_row_edge = 1'b0;
    w_row_idx  = '0;
    for (int r = 0; r < NUM_Y; r++) begin
      if (w_row_hit[r]) begin
        w_row_any  = 1'b1;
        w_row_edge = w_row_band[r];
        w_row_idx  = 3'(r);
      end
    end
  end

  logic [c_vga_bus_size-1:0] r1_bus;
  logic                      r1_col_hit, r1_col_edge, r1_row_hit, r1_row_edge;
  logic [2:0]                r1_col_idx, r1_row_idx;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r1_bus      <= '0;
      r1_col_hit  <= 1'b0;
      r1_col_edge <= 1'b0;
      r1_col_idx  <= '0;
      r1_row_hit  <= 1'b0;
      r1_row_edge <= 1'b0;
      r1_row_idx  <= '0;
    end else begin
      r1_bus      <= vga_in;
      r1_col_hit  <= w_col_any;
      r1_col_edge <= w_col_edge;
      r1_col_idx  <= w_col_idx;
      r1_row_hit  <= w_row_any;
      r1_row_edge <= w_row_edge;
      r1_row_idx  <= w_row_idx;
    end
  end

  logic [c_entry_w-1:0] w_entry;
  logic                 w_at_cursor;
  card_state_e          w_state;
  logic [11:0]          w_rgb;

  always_comb begin
    w_entry     = '0;
    w_at_cursor = 1'b0;
    for (int r = 0; r < NUM_Y; r++) begin
      for (int c = 0; c < NUM_X; c++) begin
        if (r1_row_idx == 3'(r) && r1_col_idx == 3'(c)) begin
          w_entry     = w_active_bank[(r*NUM_X + c)*c_entry_w +: c_entry_w];
          w_at_cursor = (cursor_idx == IDX_W'(r*NUM_X + c));
        end
      end
    end
  end

  assign w_state = card_state_e'(w_entry[c_face_w +: c_state_w]);

  always_comb begin
    w_rgb = r1_bus[c_rgb_lsb +: 12];
    if (!r1_bus[c_hblnk_bit] && !r1_bus[c_vblnk_bit] && r1_col_hit && r1_row_hit) begin
      if (cursor_en && w_at_cursor && (r1_col_edge || r1_row_edge)) begin
        w_rgb = CURSOR_COLOR;
      end else begin
        case (w_state)
          CARD_HIDDEN:   w_rgb = BACK_COLOR;
          CARD_REVEALED: w_rgb = face_color(w_entry[c_face_w-1:0]);
          CARD_MATCHED:  w_rgb = MATCH_COLOR;
          default:       w_rgb = r1_bus[c_rgb_lsb +: 12];
        endcase
      end
    end
  end

  logic [c_vga_bus_size-1:0] r2_bus;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) r2_bus <= '0;
    else      r2_bus <= {r1_bus[c_vga_bus_size-1:12], w_rgb};
  end

  assign vga_out = r2_bus;

endmodule
`default_nettype wire
